seven_segment_scan: RTL

- Time-multiplexed driver for an N-digit common-anode seven-segment display bank.
- Holds a displayed word and a shadow word; a valid/ready handshake loads the shadow.
- The shadow is promoted at frame boundaries only, so a frame never mixes old and new digits.
- Per-digit status codes override the hex glyph with U (contention) or H (high impedance), for bitstream-network debug on board displays.

---
 rtl/seven_segment_pkg.sv | 33 +++
 rtl/seg_glyph_decode.sv | 22 ++
 rtl/seven_segment_scan.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/seven_segment_pkg.sv
// Shared glyph constants, hex table and status-code type for the seven-segment scanner.
// Purely declarative; no latency.
// No flow control here; consumers decide when glyphs are sampled.
package seven_segment_pkg;

    // Per-digit status codes as presented on the status input (2 bits per digit)
    typedef enum logic [1:0] {
        HEX   = 2'b00,
        UNDEF = 2'b01,
        HIGHZ = 2'b10
    } seg_status_t;

    // Segment order is g..a, active-low
    localparam logic [6:0] GLYPH_H     = 7'b0001001;
    localparam logic [6:0] GLYPH_U     = 7'b1000001;
    localparam logic [6:0] GLYPH_BLANK = 7'h7F;

    localparam logic [6:0] HEX_GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Code 1x means high impedance regardless of the low bit, so H outranks U
    function automatic seg_status_t status_class(input logic [1:0] code);
        if (code[1]) begin
            return HIGHZ;
        end else if (code[0]) begin
            return UNDEF;
        end
        return HEX;
    endfunction

endpackage

// File: rtl/seg_glyph_decode.sv
// Nibble + status code to active-low seven-segment glyph (H > U > hex).
// Latency: combinational, zero cycles.
// No flow control; output follows inputs.
module seg_glyph_decode
    import seven_segment_pkg::*;
(
    input  logic [3:0] i_nibble,
    input  logic [1:0] i_status,
    output logic [6:0] o_glyph
);

    // Status override takes priority over the hex table lookup
    always_comb begin
        o_glyph = HEX_GLYPH[i_nibble];
        case (status_class(i_status))
            HIGHZ:   o_glyph = GLYPH_H;
            UNDEF:   o_glyph = GLYPH_U;
            default: o_glyph = HEX_GLYPH[i_nibble];
        endcase
    end

endmodule

// File: rtl/seven_segment_scan.sv
// Time-multiplexed N-digit common-anode display driver with shadow word promoted at frame boundaries.
// Latency: seg/an registered one cycle behind prescaler/index; loaded data shows from the next frame start.
// Backpressure: load_ready low while a shadow word is pending; option SEVEN_SEGMENT_SCAN_LZB_EN adds leading-zero blanking.
module seven_segment_scan
    import seven_segment_pkg::*;
#(
    parameter int N_DIGITS = 4,
    parameter int SCAN_DIV = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*N_DIGITS-1:0]   value,
    input  logic [2*N_DIGITS-1:0]   status,
    output logic [6:0]              seg,
    output logic [N_DIGITS-1:0]     an,
    output logic                    frame_start
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam int DW = (N_DIGITS == 1) ? 1 : $clog2(N_DIGITS);

    logic [CW-1:0]          r_presc;
    logic [DW-1:0]          r_digit;
    logic [4*N_DIGITS-1:0]  r_disp_val;
    logic [2*N_DIGITS-1:0]  r_disp_st;
    logic [4*N_DIGITS-1:0]  r_shad_val;
    logic [2*N_DIGITS-1:0]  r_shad_st;
    logic                   r_pending;
    logic                   r_frame_start;
    logic [6:0]             r_seg;
    logic [N_DIGITS-1:0]    r_an;

    logic                   w_tick;
    logic                   w_last_digit;
    logic                   w_boundary;
    logic                   w_xfer;
    logic [3:0]             w_nibble;
    logic [1:0]             w_status;
    logic [6:0]             w_glyph;
    logic                   w_blank;
    logic [6:0]             w_seg_next;
    logic [N_DIGITS-1:0]    w_an_lit;

    assign w_tick       = (r_presc == CW'(SCAN_DIV - 1));
    assign w_last_digit = (r_digit == DW'(N_DIGITS - 1));
    assign w_boundary   = w_tick && w_last_digit;
    assign w_xfer       = load_valid && !r_pending;

    assign load_ready   = !r_pending;
    assign frame_start  = r_frame_start;
    assign seg          = r_seg;
    assign an           = r_an;

    // Select the digit currently being scanned from the displayed word
    assign w_nibble = r_disp_val[4*r_digit +: 4];
    assign w_status = r_disp_st[2*r_digit +: 2];
    assign w_an_lit = ~(N_DIGITS'(1) << r_digit);

    seg_glyph_decode u_decode (
        .i_nibble (w_nibble),
        .i_status (w_status),
        .o_glyph  (w_glyph)
    );

`ifdef SEVEN_SEGMENT_SCAN_LZB_EN
    logic [N_DIGITS-1:0] w_lead_zero;
    logic                w_run;

    // Walk down from the top digit; a digit is a leading zero while every digit above it is too
    always_comb begin
        w_lead_zero = '0;
        w_run       = 1'b1;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            w_run          = w_run && (r_disp_val[4*i +: 4] == 4'h0) && (r_disp_st[2*i +: 2] == 2'b00);
            w_lead_zero[i] = w_run;
        end
    end

    // Digit 0 always shows something so an all-zero word still reads as 0
    assign w_blank = w_lead_zero[r_digit] && (r_digit != '0);
`else
    assign w_blank = 1'b0;
`endif

    assign w_seg_next = w_blank ? GLYPH_BLANK : w_glyph;

    // Prescaler counts out each digit slot; digit index steps on the last cycle of a slot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc <= '0;
            r_digit <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
            r_digit <= w_last_digit ? '0 : r_digit + 1'b1;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    // Shadow load on handshake; promotion to the display only on a frame boundary so frames never mix words
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_disp_val <= '0;
            r_disp_st  <= '0;
            r_shad_val <= '0;
            r_shad_st  <= '0;
            r_pending  <= 1'b0;
        end else if (w_xfer) begin
            // Only possible when nothing is pending, so there is nothing to promote this cycle
            r_shad_val <= value;
            r_shad_st  <= status;
            r_pending  <= 1'b1;
        end else if (w_boundary && r_pending) begin
            r_disp_val <= r_shad_val;
            r_disp_st  <= r_shad_st;
            r_pending  <= 1'b0;
        end
    end

    // Registered drive: blank the bank for the first cycle of each slot to avoid ghosting between digits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_start <= 1'b0;
            r_seg         <= GLYPH_BLANK;
            r_an          <= '1;
        end else begin
            r_frame_start <= w_boundary;
            if (r_presc == '0) begin
                r_seg <= GLYPH_BLANK;
                r_an  <= '1;
            end else begin
                r_seg <= w_seg_next;
                r_an  <= w_an_lit;
            end
        end
    end

endmodule
